// File: rtl/cont13_checker.sv
// Successor checker for a mod-N counter: flags illegal steps, counts
// wraps in BCD and drives a two-digit multiplexed 7-segment display.
module cont13_checker #(
    parameter int MODULUS     = 13,
    parameter int SCAN_DIV    = 4,
    parameter int WRAP_DIGITS = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [3:0]               y_in,
    input  logic                     clear,
    output logic                     wrap_pulse,
    output logic [4*WRAP_DIGITS-1:0] wrap_bcd,
    output logic                     wrap_ovf,
    output logic                     err_pulse,
    output logic                     err,
    output logic [6:0]               seg,
    output logic [1:0]               an
);

    typedef enum logic [1:0] {SYNC, TRACK, FAULT} state_t;

    localparam logic [4:0] MOD_W = 5'(MODULUS);
    localparam logic [3:0] LAST  = 4'(MODULUS - 1);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    state_t                     state;
    logic [3:0]                 prev;
    logic                       in_range;
    logic                       step_ok;
    logic [4*WRAP_DIGITS-1:0]   bcd_inc;
    logic                       bcd_all9;
    logic [SW-1:0]              scan_cnt;
    logic                       sel;
    logic                       tens;
    logic [3:0]                 units;

    assign in_range = {1'b0, y_in} < MOD_W;

    // Legal successor: +1, or back to 0 from the last state
    always_comb begin
        step_ok = 1'b0;
        if (prev == LAST)
            step_ok = (y_in == 4'd0);
        else
            step_ok = ({1'b0, y_in} == ({1'b0, prev} + 5'd1));
    end

    // BCD increment with decimal ripple carry; carry out means all 9s
    always_comb begin
        bcd_inc  = wrap_bcd;
        bcd_all9 = 1'b1;
        for (int i = 0; i < WRAP_DIGITS; i++) begin
            if (bcd_all9) begin
                if (wrap_bcd[4*i +: 4] == 4'd9) begin
                    bcd_inc[4*i +: 4] = 4'd0;
                end else begin
                    bcd_inc[4*i +: 4] = wrap_bcd[4*i +: 4] + 4'd1;
                    bcd_all9 = 1'b0;
                end
            end
        end
    end

    // Checker FSM with registered pulses and statistics
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= SYNC;
            prev       <= 4'd0;
            wrap_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            wrap_bcd   <= '0;
            wrap_ovf   <= 1'b0;
            err        <= 1'b0;
        end else begin
            wrap_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            if (clear) begin
                state    <= SYNC;
                err      <= 1'b0;
                wrap_bcd <= '0;
                wrap_ovf <= 1'b0;
                prev     <= in_range ? y_in : 4'd0;
            end else begin
                unique case (state)
                    SYNC: begin
                        if (in_range) begin
                            prev  <= y_in;
                            state <= TRACK;
                        end else begin
                            err_pulse <= 1'b1;
                            err       <= 1'b1;
                        end
                    end
                    TRACK: begin
                        if (in_range && step_ok) begin
                            prev <= y_in;
                            if (prev == LAST) begin
                                wrap_pulse <= 1'b1;
                                wrap_bcd   <= bcd_inc;
                                if (bcd_all9)
                                    wrap_ovf <= 1'b1;
                            end
                        end else begin
                            err_pulse <= 1'b1;
                            err       <= 1'b1;
                            state     <= FAULT;
                            prev      <= in_range ? y_in : 4'd0;
                        end
                    end
                    FAULT: begin
                        prev <= in_range ? y_in : 4'd0;
                    end
                    default: state <= SYNC;
                endcase
            end
        end
    end

    // Digit scan: each digit stays active for SCAN_DIV clocks
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scan_cnt <= '0;
            sel      <= 1'b0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            sel      <= ~sel;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    function automatic logic [6:0] dec7(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = 7'h7F;
        endcase
        return p;
    endfunction

    // Split prev into decimal digits and drive the active one
    always_comb begin
        tens  = (prev >= 4'd10);
        units = tens ? (prev - 4'd10) : prev;
        if (sel) begin
            an  = 2'b01;
            seg = tens ? dec7(4'd1) : 7'h7F;
        end else begin
            an  = 2'b10;
            seg = dec7(units);
        end
    end

endmodule

// File: tb/tb_cont13_checker.sv
// Table-driven bench for cont13_checker plus directed sequences for
// long counting, async reset and display scanning.
module tb_cont13_checker;

    logic       clock;
    logic       reset;
    logic [3:0] y_in;
    logic       clear;
    logic       wrap_pulse;
    logic [7:0] wrap_bcd;
    logic       wrap_ovf;
    logic       err_pulse;
    logic       err;
    logic [6:0] seg;
    logic [1:0] an;

    int checks = 0;
    int errors = 0;

    cont13_checker #(.MODULUS(13), .SCAN_DIV(4), .WRAP_DIGITS(2)) dut (
        .clock(clock), .reset(reset), .y_in(y_in), .clear(clear),
        .wrap_pulse(wrap_pulse), .wrap_bcd(wrap_bcd),
        .wrap_ovf(wrap_ovf), .err_pulse(err_pulse), .err(err),
        .seg(seg), .an(an)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  y;
        logic        clr;
        logic [11:0] exp;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic add(input int y, input int clr, input int wp,
                       input int ep, input int er, input int bcd);
        vec_t v;
        v.y   = 4'(y);
        v.clr = 1'(clr);
        v.exp = {1'(wp), 1'(ep), 1'(er), 1'b0, 8'(bcd)};
        vq.push_back(v);
    endtask

    task automatic step(input logic [3:0] y, input logic c);
        y_in  = y;
        clear = c;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [6:0] pat(input int d);
        logic [6:0] p;
        case (d)
            0: p = 7'b1000000;
            1: p = 7'b1111001;
            7: p = 7'b1111000;
            9: p = 7'b0010000;
            default: p = 7'h7F;
        endcase
        return p;
    endfunction

    task automatic scan_check(input int v);
        logic [1:0] last_an;
        int run;
        bit seen;
        logic [6:0] u_pat;
        logic [6:0] t_pat;
        u_pat = pat(v >= 10 ? v - 10 : v);
        t_pat = (v >= 10) ? pat(1) : 7'h7F;
        repeat (3) step(4'(v), 1'b0);
        last_an = an;
        run = 0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step(4'(v), 1'b0);
            chk("an_onehot", 32'(an == 2'b10 || an == 2'b01), 32'd1);
            chk("seg", 32'(seg), 32'(an == 2'b01 ? t_pat : u_pat));
            if (an != last_an) begin
                if (seen)
                    chk("scan_len", run, 4);
                seen = 1;
                run = 1;
                last_an = an;
            end else begin
                run++;
            end
        end
    endtask

    initial begin
        int wraps;
        logic [3:0] y;
        logic [7:0] eb;

        reset = 1'b1;
        clear = 1'b0;
        y_in  = 4'd0;
        #12;
        chk("reset_flags",
            {20'd0, wrap_pulse, err_pulse, err, wrap_ovf, wrap_bcd},
            32'd0);
        chk("reset_disp", {23'd0, an, seg}, {23'd0, 2'b10, 7'b1000000});
        reset = 1'b0;

        for (int i = 0; i <= 12; i++) add(i, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 1);
        add(1, 0, 0, 0, 0, 1);
        for (int i = 2; i <= 4; i++) add(i, 0, 0, 0, 0, 1);
        add(6, 0, 0, 1, 1, 1);
        for (int i = 7; i <= 12; i++) add(i, 0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 1, 1);
        add(0, 1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0);
        add(14, 0, 0, 1, 1, 0);
        add(12, 1, 0, 0, 0, 0);
        add(12, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 1);
        for (int i = 1; i <= 12; i++) add(i, 0, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0);
        add(5, 0, 0, 0, 0, 0);
        add(6, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0);
        add(15, 0, 0, 1, 1, 0);
        add(15, 0, 0, 1, 1, 0);
        add(3, 0, 0, 0, 1, 0);
        add(4, 0, 0, 0, 1, 0);
        add(6, 0, 0, 1, 1, 0);

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].y, vq[i].clr);
            chk($sformatf("vec%0d", i),
                {20'd0, wrap_pulse, err_pulse, err, wrap_ovf, wrap_bcd},
                {20'd0, vq[i].exp});
        end

        step(4'd0, 1'b1);
        chk("long_clear", {20'd0, wrap_pulse, err_pulse, err, wrap_ovf,
            wrap_bcd}, 32'd0);
        wraps = 0;
        for (int k = 1; k <= 1300; k++) begin
            y = 4'(k % 13);
            step(y, 1'b0);
            if (y == 4'd0) wraps++;
            eb = {4'((wraps % 100) / 10), 4'(wraps % 10)};
            chk($sformatf("long%0d", k),
                {20'd0, wrap_pulse, err_pulse, err, wrap_ovf, wrap_bcd},
                {20'd0, y == 4'd0, 1'b0, 1'b0, wraps >= 100, eb});
        end

        step(4'd1, 1'b0);
        step(4'd9, 1'b0);
        chk("pre_reset", {29'd0, err_pulse, err, wrap_ovf}, 32'd7);
        step(4'd9, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_flags",
            {20'd0, wrap_pulse, err_pulse, err, wrap_ovf, wrap_bcd},
            32'd0);
        chk("async_disp", {23'd0, an, seg}, {23'd0, 2'b10, 7'b1000000});
        #2;
        reset = 1'b0;
        step(4'd5, 1'b0);
        chk("post_rst5", {30'd0, err_pulse, err}, 32'd0);
        step(4'd6, 1'b0);
        chk("post_rst6", {29'd0, wrap_pulse, err_pulse, err}, 32'd0);

        step(4'd11, 1'b1);
        scan_check(11);
        scan_check(7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cont13_checker.md
Name: cont13_checker

Overview:
- Downstream consumer of the mod-13 counter output (0..12, one step per clock).
- Checks that every sampled value is the legal successor of the previous one, and counts completed wraps (12->0) as a BCD value.
- Drives a two-digit multiplexed seven-segment display of the current count for board-level observation.
- Sits between the counter and the board I/O.

Parameters:
- MODULUS, 13, number of counter states; legal values are 0..MODULUS-1 (2..16 supported).
- SCAN_DIV, 4, clock cycles each display digit stays active; must be >= 1.
- WRAP_DIGITS, 2, number of BCD digits in the wrap counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- y_in  in  4  counter value, sampled every rising edge.
- clear  in  1  synchronous; restarts checking and zeroes the statistics.
- wrap_pulse  out  1  one-cycle pulse per legal MODULUS-1 -> 0 transition.
- wrap_bcd  out  4*WRAP_DIGITS  BCD wrap count; digit 0 in the LSBs.
- wrap_ovf  out  1  sticky; set when wrap_bcd rolls from all-9s to 0.
- err_pulse  out  1  one-cycle pulse per illegal sample.
- err  out  1  sticky error flag.
- seg  out  7  active-low segments {g,f,e,d,c,b,a} for the active digit.
- an  out  2  active-low digit enables; an[0] is units, an[1] is tens.

Behaviour:
Reset values (reset asserted):
- state=SYNC, prev=0; all pulses 0; wrap_bcd=0; wrap_ovf=0; err=0.
- Scan counter 0, an=2'b10 (units active), seg=7'b1000000 (shows "0").

FSM, evaluated on each rising edge with sample s=y_in:
- SYNC: if s<MODULUS, prev<=s and go to TRACK. Otherwise stay in SYNC and pulse err_pulse; err is set.
- TRACK: a sample is legal if s==prev+1 when prev<MODULUS-1, or s==0 when prev==MODULUS-1.
  - Legal: prev<=s. If the legal step was MODULUS-1 -> 0, wrap_pulse=1 in the next cycle and wrap_bcd increments by 1 in BCD with decimal carry between digits.
  - Illegal (includes s>=MODULUS): err_pulse=1 in the next cycle, err<=1, go to FAULT. prev<=s if s<MODULUS, else prev<=0.
- FAULT: no further checking and no wrap counting. prev tracks s (0 if s is out of range). err stays 1. Leave FAULT only via clear or reset.
- clear=1 in any state: next state SYNC; err, wrap_bcd, wrap_ovf and both pulses are cleared that cycle. clear has priority over a coincident wrap or error.

Latency and counter rules:
- Both pulses are registered, 1 cycle after the sampling edge. Each is high for exactly one cycle per event.
- Consecutive wraps each produce their own pulse.
- BCD rollover: at value 99 (WRAP_DIGITS=2), the next wrap gives 00 and sets wrap_ovf. wrap_pulse still fires.

Display:
- tens = (prev>=10) ? 1 : 0; units = prev - 10*tens.
- Decode digits 0-9 to standard active-low patterns. A tens digit of 0 is blanked (seg=7'h7F while an[1] is active).
- The scan counter counts 0..SCAN_DIV-1. At SCAN_DIV-1 the active digit toggles.
- an is always exactly one-hot low, with no overlap cycle.
- The display is updated from registered prev, so it lags y_in by 1 cycle.

Mid-operation reset:
- Asynchronous clear to the reset values above, independent of the clock.
- On release, the first sampled edge is handled as SYNC.

Test Plan:
- Reset, then y_in = 0,1,...,12,0,1 -> err=0 throughout; wrap_pulse high exactly 1 cycle after the 12->0 sample; wrap_bcd=8'h01.
- Continuous legal counting for 100 full cycles (1300 clocks) -> wrap_bcd steps 8'h09->8'h10 with decimal carry; at the 100th wrap wrap_bcd=8'h00 and wrap_ovf=1.
- Sequence 3,4,6 -> err_pulse 1 cycle after the 6 sample; err=1; state FAULT. A following 7->8->...->12->0 run produces no wrap_pulse and no wrap_bcd change.
- y_in=14 while in TRACK -> err_pulse and err=1. Then clear=1 in the same cycle as a 12->0 step -> err=0, wrap_bcd=0, no wrap_pulse, state SYNC.
- y_in held at 11, SCAN_DIV=4 -> an alternates 2'b10/2'b01 every 4 clocks; seg=7'b1111001 ("1") for both digits. With y_in=7, the tens digit shows 7'h7F.
- Assert reset asynchronously between edges mid-count -> all outputs return to their reset values immediately. After release, y_in=5,6 is legal with no error.
